pipe_ifid_elastic: RTL and testbench
====================================

Name: pipe_ifid_elastic

Overview:
Parametrised IF/ID pipeline stage that carries PC and fetched instruction from fetch to decode. It extends the plain always-enabled IF/ID register with a valid/ready handshake and a 2-entry skid buffer, so decode back-pressure never needs a combinational ready path into fetch. It also adds a branch/jump flush that squashes in-flight slots and substitutes a NOP, and a saturating stall-cycle counter for performance monitoring.

Parameters:
PC_W, 16, width of program counter field
INSTR_W, 16, width of instruction field
NOP_INSTR, 16'h0000, instruction value driven on out_instr whenever out_valid=0 (width INSTR_W)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset; rst=0 clears all state immediately
in_valid  in  1  fetch presents a beat
in_ready  out  1  stage can accept a beat; registered, no combinational input dependency
in_pc  in  PC_W  PC of fetched instruction
in_instr  in  INSTR_W  fetched instruction
flush  in  1  squash all held and incoming beats this cycle
out_valid  out  1  decode beat available
out_ready  in  1  decode accepts beat
out_pc  out  PC_W  PC to decode
out_instr  out  INSTR_W  instruction to decode (NOP_INSTR when out_valid=0)
occupancy  out  2  number of valid entries held, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst=0, async): main and skid entries invalid, data fields 0; in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, occupancy=0, stall_cnt=0.
- Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready. Data is held stable on out_* while out_valid=1 and out_ready=0.
- Latency: an accepted beat appears on out_* the next cycle when the stage is empty, giving 1 cycle of latency.
- Entries: main drives out_*; skid holds overflow.
  - accept, main empty or consumed this cycle, skid empty: beat -> main.
  - accept, main valid and not consumed: beat -> skid.
  - consume with skid valid: skid -> main, skid invalid; an accept in the same cycle writes main? No: in_ready is already 0 when skid is valid, so accept cannot occur.
- in_ready next = !skid_valid_next. Full (occupancy=2) means in_ready=0, and no beat is lost.
- Order preserved: skid contents always older than any later-accepted beat.
- Flush (highest priority over accept/consume): next cycle main and skid are invalid, occupancy=0, in_ready=1. An incoming beat in the flush cycle is dropped. A consume in the flush cycle still counts as delivered to decode, because decode owns squashing it.
- out_instr = main_valid ? main_instr : NOP_INSTR; out_pc = main_pc regardless.
- stall_cnt: +1 each cycle out_valid=1 & out_ready=0; saturates at 2^CNT_W-1 with no wrap. cnt_clr has priority over increment, giving 0 next cycle. flush does not affect stall_cnt.
- Reset asserted mid-transfer: all beats lost, outputs return to reset values asynchronously. Deassertion is synchronised externally.

Decomposition:
- Shared package: PC_W/INSTR_W defaults and NOP_INSTR encoding, shared with decode flush logic and the ID/EX stage successor.
- Sub-module ifid_slot: one valid bit plus PC/instr register with load enable, clear, and async active-low reset; instantiated twice (main, skid). Control FSM and stall counter stay in the top.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_instr=NOP_INSTR, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, beats PC=0x0000..0x0006 step 2, instr 0xA001..0xA004 on consecutive cycles -> same sequence on out_* one cycle later, in_ready stays 1, occupancy<=1.
- Back-pressure: out_ready=0 while pushing PC 0x10, 0x12, 0x14 -> in_ready falls after 2 accepts, 0x14 held at fetch. After 3 stalled cycles stall_cnt=3. Raising out_ready delivers 0x10, 0x12, 0x14 in order.
- Flush when full: occupancy=2, flush=1 with in_valid=1 (PC 0x20) -> next cycle out_valid=0, out_instr=NOP_INSTR, occupancy=0, in_ready=1; 0x20 never appears.
- Counter: CNT_W=4, hold stall 20 cycles -> stall_cnt saturates at 15; cnt_clr=1 in the same cycle as a stall -> stall_cnt=0.
- Async reset mid-stall: occupancy=2, drop rst between clock edges -> outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/pipe_ifid_elastic_pkg.sv
// Shared IF/ID definitions: default field widths, the NOP encoding, the
// occupancy/state encoding and the beat payload used by decode and ID/EX.
package pipe_ifid_elastic_pkg;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 16;

  // Instruction substituted whenever no valid beat is presented to decode.
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;

  // Stage fill level; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ifid_state_e;

  // Beat payload at the default widths, for neighbouring stages.
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } ifid_beat_t;

endpackage

// File: rtl/pipe_ifid_elastic_if.sv
// Valid/ready beat channel carrying PC and instruction.
//   master: drives valid, pc, instr; receives ready
//   slave : receives valid, pc, instr; drives ready
interface pipe_ifid_elastic_if
  import pipe_ifid_elastic_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) ();

  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);

endinterface

// File: rtl/ifid_slot.sv
// One IF/ID holding slot: valid bit plus PC/instruction register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture pc_i/instr_i and mark valid
//   clr_i      : invalidate (wins over load_i); data is left untouched
//   valid_o, pc_o, instr_o : registered slot contents
module ifid_slot
  import pipe_ifid_elastic_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pipe_ifid_elastic.sv
// Elastic IF/ID stage: 2-entry (main + skid) buffer between fetch and decode
// with registered in_ready, flush squash and a saturating stall counter.
//   clk, rst   : clock, asynchronous active-low reset
//   in_if      : fetch side beat channel (slave)
//   out_if     : decode side beat channel (master); instr is NOP when invalid
//   flush      : squash held and incoming beats this cycle
//   cnt_clr    : synchronous clear of stall_cnt
//   occupancy  : number of held beats (0..2)
//   stall_cnt  : saturating count of cycles with out valid and not ready
module pipe_ifid_elastic
  import pipe_ifid_elastic_pkg::*;
#(
  parameter int unsigned        PC_W      = PC_W_DEF,
  parameter int unsigned        INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int unsigned        CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_ifid_elastic_if.slave   in_if,
  pipe_ifid_elastic_if.master  out_if,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  ifid_state_e        state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               accept_c, consume_c;
  logic               main_load, main_clr, main_from_skid;
  logic               skid_load, skid_clr;
  logic [PC_W-1:0]    main_pc_in;
  logic [INSTR_W-1:0] main_instr_in;

  logic               main_valid, skid_valid;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;

  assign accept_c  = in_if.valid & in_ready_q;
  assign consume_c = main_valid & out_if.ready;

  // Main refills from skid when draining a full stage, otherwise from fetch.
  assign main_pc_in    = main_from_skid ? skid_pc    : in_if.pc;
  assign main_instr_in = main_from_skid ? skid_instr : in_if.instr;

  ifid_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .pc_i    (main_pc_in),
    .instr_i (main_instr_in),
    .valid_o (main_valid),
    .pc_o    (main_pc),
    .instr_o (main_instr)
  );

  ifid_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .pc_i    (in_if.pc),
    .instr_i (in_if.instr),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Fill-level FSM: steers slot loads/clears; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;

    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
      state_d  = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          unique case ({accept_c, consume_c})
            2'b11: main_load = 1'b1;
            2'b01: begin
              main_clr = 1'b1;
              state_d  = ST_EMPTY;
            end
            2'b10: begin
              skid_load = 1'b1;
              state_d   = ST_FULL;
            end
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only a consume can move the stage.
          if (consume_c) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (main_valid && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = main_valid;
  assign out_if.pc    = main_pc;
  assign out_if.instr = main_valid ? main_instr : NOP_INSTR;
  assign occupancy    = 2'(state_q);
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ifid_elastic.sv
// Scoreboard bench for pipe_ifid_elastic.
module tb_pipe_ifid_elastic;

  localparam int unsigned PW      = 16;
  localparam int unsigned IW      = 16;
  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
  localparam logic [IW-1:0] NOP   = 16'hF00F;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          cnt_clr;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_ifid_elastic_if #(.PC_W(PW), .INSTR_W(IW)) in_if ();
  pipe_ifid_elastic_if #(.PC_W(PW), .INSTR_W(IW)) out_if ();

  pipe_ifid_elastic #(
    .PC_W(PW), .INSTR_W(IW), .NOP_INSTR(NOP), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in_if),
    .out_if    (out_if),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       sb_q[$];
  int unsigned exp_cnt;
  int          n_checks;
  int          n_fail;
  bit          last_accept;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cyc();
    beat_t hd;
    bit    acc;
    bit    con;
    @(negedge clk);
    check_eq("out_valid", 32'(out_if.valid), 32'(sb_q.size() != 0));
    check_eq("in_ready", 32'(in_if.ready), 32'(sb_q.size() < 2));
    check_eq("occupancy", 32'(occupancy), 32'(sb_q.size()));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
    if (sb_q.size() == 0) begin
      check_eq("nop_instr", 32'(out_if.instr), 32'(NOP));
    end else begin
      check_eq("out_pc", 32'(out_if.pc), 32'(sb_q[0].pc));
      check_eq("out_instr", 32'(out_if.instr), 32'(sb_q[0].instr));
    end
    acc = rst && in_if.valid && (sb_q.size() < 2);
    con = rst && (sb_q.size() != 0) && out_if.ready;
    last_accept = acc;
    if (!rst) begin
      sb_q.delete();
      exp_cnt = 0;
    end else begin
      if (cnt_clr) exp_cnt = 0;
      else if ((sb_q.size() != 0) && !out_if.ready && (exp_cnt != CNT_MAX)) exp_cnt++;
      if (con) void'(sb_q.pop_front());
      if (flush) begin
        sb_q.delete();
      end else if (acc) begin
        hd.pc    = in_if.pc;
        hd.instr = in_if.instr;
        sb_q.push_back(hd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic push(input logic [PW-1:0] pc, input logic [IW-1:0] instr);
    in_if.valid = 1'b1;
    in_if.pc    = pc;
    in_if.instr = instr;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (last_accept) break;
    end
    check_eq("push_accepted", 32'(last_accept), 32'd1);
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    out_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      cyc();
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seq;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    cnt_clr      = 1'b0;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.pc     = 16'h0099;
    in_if.instr  = 16'h1234;

    // Reset held with fetch presenting a beat.
    #1 rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_if.valid), 32'd0);
    check_eq("rst_out_instr", 32'(out_if.instr), 32'(NOP));
    check_eq("rst_out_pc", 32'(out_if.pc), 32'd0);
    check_eq("rst_in_ready", 32'(in_if.ready), 32'd1);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    cyc();
    cyc();
    in_if.valid = 1'b0;
    rst = 1'b1;

    // Streaming at full rate.
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_if.valid = 1'b1;
      in_if.pc    = 16'(2 * i);
      in_if.instr = 16'hA001 + 16'(i);
      cyc();
      check_eq("stream_in_ready", 32'(in_if.ready), 32'd1);
      check_eq("stream_pc", 32'(out_if.pc), 32'(2 * i));
    end
    in_if.valid = 1'b0;
    cyc();
    cyc();

    // Back-pressure fills main + skid, third beat waits at fetch.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    out_if.ready = 1'b0;
    push(16'h0010, 16'hB010);
    push(16'h0012, 16'hB012);
    in_if.valid = 1'b1;
    in_if.pc    = 16'h0014;
    in_if.instr = 16'hB014;
    check_eq("bp_in_ready", 32'(in_if.ready), 32'd0);
    check_eq("bp_occupancy", 32'(occupancy), 32'd2);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    cyc();
    cyc();
    cyc();
    check_eq("bp_stall3", 32'(stall_cnt), 32'd3);
    out_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_accept) break;
    end
    check_eq("bp_0x14_accepted", 32'(last_accept), 32'd1);
    in_if.valid = 1'b0;
    drain();

    // Flush while full, with an incoming beat that must be dropped.
    out_if.ready = 1'b0;
    push(16'h0030, 16'hC030);
    push(16'h0032, 16'hC032);
    check_eq("fl_full", 32'(occupancy), 32'd2);
    in_if.valid = 1'b1;
    in_if.pc    = 16'h0020;
    in_if.instr = 16'hC020;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_if.valid = 1'b0;
    check_eq("fl_out_valid", 32'(out_if.valid), 32'd0);
    check_eq("fl_out_instr", 32'(out_if.instr), 32'(NOP));
    check_eq("fl_occupancy", 32'(occupancy), 32'd0);
    check_eq("fl_in_ready", 32'(in_if.ready), 32'd1);
    out_if.ready = 1'b1;
    cyc();
    cyc();

    // Counter saturation and clear-over-increment.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    out_if.ready = 1'b0;
    push(16'h0040, 16'hD040);
    repeat (20) cyc();
    check_eq("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check_eq("cnt_clr", 32'(stall_cnt), 32'd0);
    drain();

    // Asynchronous reset between clock edges while full.
    out_if.ready = 1'b0;
    push(16'h0050, 16'hE050);
    push(16'h0052, 16'hE052);
    check_eq("ar_full", 32'(occupancy), 32'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("ar_out_valid", 32'(out_if.valid), 32'd0);
    check_eq("ar_out_instr", 32'(out_if.instr), 32'(NOP));
    check_eq("ar_out_pc", 32'(out_if.pc), 32'd0);
    check_eq("ar_occupancy", 32'(occupancy), 32'd0);
    check_eq("ar_in_ready", 32'(in_if.ready), 32'd1);
    check_eq("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    sb_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // Random traffic with occasional flush and counter clear.
    seq = 0;
    for (int i = 0; i < 300; i++) begin
      in_if.valid  = 1'($urandom_range(0, 1));
      in_if.pc     = 16'(seq * 2);
      in_if.instr  = 16'h5000 + 16'(seq);
      out_if.ready = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      cnt_clr      = ($urandom_range(0, 31) == 0);
      cyc();
      if (last_accept) seq++;
    end
    in_if.valid = 1'b0;
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
